// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction prefetch queue.
//   fetch_entry_t    : one buffered {pc, instr} pair, as stored in the queue
//   FETCH_WIDTH      : address/data width used by the entry type
//   DEFAULT_RESET_PC : fetch PC after reset
//   DEFAULT_PC_INC   : fetch PC advance per fetched word
//   ENTRY_WIDTH      : flattened width of one entry
//   packEntry        : builds an entry from its two fields
package fetch_pkg;

  localparam int FETCH_WIDTH = 32;
  localparam logic [FETCH_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [FETCH_WIDTH-1:0] DEFAULT_PC_INC   = 32'd4;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0] pc;
    logic [FETCH_WIDTH-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_WIDTH = $bits(fetch_entry_t);

  function automatic fetch_entry_t packEntry(input logic [FETCH_WIDTH-1:0] pc,
                                             input logic [FETCH_WIDTH-1:0] instr);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Storage array for the prefetch queue: DEPTH entries, one synchronous
// write port and one asynchronous read port. Storage has no reset; the
// control logic in fetch_queue decides which entries are meaningful.
//   clk     : clock, rising edge
//   wr_en   : write wr_data into slot wr_addr at the clock edge
//   wr_addr : slot written
//   wr_data : flattened fetch_entry_t to store
//   rd_addr : slot read
//   rd_data : flattened fetch_entry_t at rd_addr (combinational)
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [PTR_W-1:0]       wr_addr,
  input  logic [ENTRY_WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0]       rd_addr,
  output logic [ENTRY_WIDTH-1:0] rd_data
);

  logic [ENTRY_WIDTH-1:0] storage [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      storage[wr_addr] <= wr_data;
    end
  end

  assign rd_data = storage[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage. Owns the fetch PC, presents it to instruction
// memory (combinational read) and buffers {pc, instr} pairs so that decode
// stalls do not stall fetch. A redirect flushes everything and restarts
// fetch at the target.
//   clk         : clock, rising edge
//   reset       : asynchronous, active-high
//   fetch_en    : fetch allowed this cycle
//   imem_addr   : address to instruction memory (the fetch PC)
//   imem_rdata  : instruction word for imem_addr, same cycle
//   redirect    : flush queue, restart fetch at redirect_pc
//   redirect_pc : new fetch PC
//   out_valid   : head entry valid
//   out_pc      : PC of head entry (0 when empty)
//   out_instr   : instruction of head entry (0 when empty)
//   out_ready   : decode accepts head this cycle
//   count       : occupied entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = FETCH_WIDTH,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [WIDTH-1:0] PC_INC   = DEFAULT_PC_INC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_en,
  output logic [WIDTH-1:0]           imem_addr,
  input  logic [WIDTH-1:0]           imem_rdata,
  input  logic                       redirect,
  input  logic [WIDTH-1:0]           redirect_pc,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_pc,
  output logic [WIDTH-1:0]           out_instr,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0]       fetchPc_q, fetchPc_d;
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   deq, enq;
  logic [ENTRY_WIDTH-1:0] wrData, rdData;
  fetch_entry_t           headEntry;

  // A full queue may still accept a word when the head leaves in the same
  // cycle. A redirect suppresses both: the word being fetched belongs to the
  // old path, and the head is thrown away with the flush.
  assign deq = (count_q != '0) & out_ready;
  assign enq = fetch_en & ~redirect & ((count_q != FULL_COUNT) | deq);

  always_comb begin
    fetchPc_d = fetchPc_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (redirect) begin
      fetchPc_d = redirect_pc;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
    end else begin
      if (enq) begin
        tail_d    = tail_q + PTR_W'(1);
        fetchPc_d = fetchPc_q + PC_INC;
      end
      if (deq) begin
        head_d = head_q + PTR_W'(1);
      end
      if (enq && !deq) begin
        count_d = count_q + CNT_W'(1);
      end else if (!enq && deq) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchPc_q <= RESET_PC;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      fetchPc_q <= fetchPc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  assign wrData = packEntry(fetchPc_q, imem_rdata);

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (enq),
    .wr_addr (tail_q),
    .wr_data (wrData),
    .rd_addr (head_q),
    .rd_data (rdData)
  );

  assign headEntry = fetch_entry_t'(rdData);

  // Memory is never reset, so stale slot contents are masked while empty;
  // this also makes reset clear the outputs immediately.
  assign imem_addr = fetchPc_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = out_valid ? headEntry.pc    : '0;
  assign out_instr = out_valid ? headEntry.instr : '0;
  assign count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: table-driven fill/drain vectors,
// hand-written redirect, wrap and mid-stream reset sequences, then random
// traffic compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] MEM_KEY = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    logic        fen;
    logic        rdy;
    logic        expValid;
    logic [31:0] expPc;
    int          expCount;
    logic [31:0] expAddr;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        fetchEn;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        outValid;
  logic [31:0] outPc;
  logic [31:0] outInstr;
  logic        outReady;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  ent_t        modelQ[$];
  logic [31:0] modelPc;

  fetch_queue #(
    .WIDTH    (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0),
    .PC_INC   (32'd4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetchEn),
    .imem_addr   (imemAddr),
    .imem_rdata  (imemRdata),
    .redirect    (redirect),
    .redirect_pc (redirectPc),
    .out_valid   (outValid),
    .out_pc      (outPc),
    .out_instr   (outInstr),
    .out_ready   (outReady),
    .count       (count)
  );

  // Instruction memory model: each word is its address scrambled by a key.
  assign imemRdata = imemAddr ^ MEM_KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic fen, input logic rdy, input logic redir,
                               input logic [31:0] rpc);
    fetchEn    = fen;
    outReady   = rdy;
    redirect   = redir;
    redirectPc = rpc;
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelPc = 32'h0;
  endtask

  // Queue-level reference: redirect flushes; otherwise pop head if accepted,
  // then push the fetched word if there is (or will be) room.
  task automatic modelStep();
    bit doDeq, doEnq;
    ent_t e;
    if (redirect) begin
      modelQ.delete();
      modelPc = redirectPc;
    end else begin
      doDeq = (modelQ.size() > 0) && outReady;
      doEnq = fetchEn && ((modelQ.size() < DEPTH) || doDeq);
      if (doDeq) void'(modelQ.pop_front());
      if (doEnq) begin
        e.pc    = modelPc;
        e.instr = modelPc ^ MEM_KEY;
        modelQ.push_back(e);
        modelPc = modelPc + 32'd4;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [31:0] expPc, expInstr;
    expPc    = (modelQ.size() > 0) ? modelQ[0].pc    : 32'h0;
    expInstr = (modelQ.size() > 0) ? modelQ[0].instr : 32'h0;
    checkVal({tag, "_valid"}, {31'h0, outValid}, {31'h0, modelQ.size() > 0});
    checkVal({tag, "_count"}, {29'h0, count}, modelQ.size());
    checkVal({tag, "_addr"},  imemAddr, modelPc);
    checkVal({tag, "_pc"},    outPc,    expPc);
    checkVal({tag, "_instr"}, outInstr, expInstr);
  endtask

  task automatic stepCycle(input logic fen, input logic rdy, input logic redir,
                           input logic [31:0] rpc, input string tag);
    applyStimulus(fen, rdy, redir, rpc);
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  vec_t vecs[10];

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    modelReset();

    // Fill from reset with decode stalled, then drain at full.
    vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h00, 1, 32'h04};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h00, 2, 32'h08};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h00, 3, 32'h0C};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h00, 4, 32'h10};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h00, 4, 32'h10};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h04, 4, 32'h14};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h08, 4, 32'h18};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h0C, 4, 32'h1C};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 32'h10, 4, 32'h20};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 32'h14, 4, 32'h24};

    resetDut();
    checkVal("reset_valid", {31'h0, outValid}, 32'h0);
    checkVal("reset_count", {29'h0, count}, 32'h0);
    checkVal("reset_addr",  imemAddr, 32'h0);
    checkVal("reset_pc",    outPc,    32'h0);
    checkVal("reset_instr", outInstr, 32'h0);

    for (int i = 0; i < 10; i++) begin
      stepCycle(vecs[i].fen, vecs[i].rdy, 1'b0, 32'h0, $sformatf("vec%0d", i));
      checkVal($sformatf("vec%0d_tvalid", i), {31'h0, outValid}, {31'h0, vecs[i].expValid});
      checkVal($sformatf("vec%0d_tcount", i), {29'h0, count}, vecs[i].expCount);
      checkVal($sformatf("vec%0d_taddr", i), imemAddr, vecs[i].expAddr);
      checkVal($sformatf("vec%0d_tpc", i), outPc, vecs[i].expPc);
      checkVal($sformatf("vec%0d_tinstr", i), outInstr, vecs[i].expPc ^ MEM_KEY);
    end

    // Redirect with a full queue and decode ready: everything is dropped.
    resetDut();
    for (int i = 0; i < 4; i++) stepCycle(1'b1, 1'b0, 1'b0, 32'h0, "redir_fill");
    checkVal("redir_full_count", {29'h0, count}, 32'd4);
    stepCycle(1'b1, 1'b1, 1'b1, 32'h100, "redir");
    checkVal("redir_valid", {31'h0, outValid}, 32'h0);
    checkVal("redir_count", {29'h0, count}, 32'h0);
    checkVal("redir_addr",  imemAddr, 32'h100);
    stepCycle(1'b1, 1'b0, 1'b0, 32'h0, "redir_next");
    checkVal("redir_head_pc",    outPc,    32'h100);
    checkVal("redir_head_instr", outInstr, 32'hA5A5_0100);
    checkVal("redir_next_addr",  imemAddr, 32'h104);

    // PC wrap at the top of the address space.
    stepCycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, "wrap_redir");
    checkVal("wrap_addr0", imemAddr, 32'hFFFF_FFFC);
    stepCycle(1'b1, 1'b0, 1'b0, 32'h0, "wrap_a");
    checkVal("wrap_head_pc", outPc, 32'hFFFF_FFFC);
    checkVal("wrap_addr1", imemAddr, 32'h0);
    stepCycle(1'b1, 1'b0, 1'b0, 32'h0, "wrap_b");
    stepCycle(1'b0, 1'b1, 1'b0, 32'h0, "wrap_pop");
    checkVal("wrap_second_pc", outPc, 32'h0);

    // Reset asserted mid-stream clears outputs without waiting for a clock.
    resetDut();
    for (int i = 0; i < 3; i++) stepCycle(1'b1, 1'b0, 1'b0, 32'h0, "mid_fill");
    checkVal("mid_count3", {29'h0, count}, 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    checkVal("mid_rst_valid", {31'h0, outValid}, 32'h0);
    checkVal("mid_rst_count", {29'h0, count}, 32'h0);
    checkVal("mid_rst_addr",  imemAddr, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    checkOutput("mid_after");
    stepCycle(1'b1, 1'b0, 1'b0, 32'h0, "mid_restart");
    checkVal("mid_restart_pc", outPc, 32'h0);

    // Random traffic against the reference model.
    for (int i = 0; i < 1000; i++) begin
      logic fen, rdy, redir;
      logic [31:0] rpc;
      fen   = ($urandom_range(0, 3) != 0);
      rdy   = ($urandom_range(0, 1) != 0);
      redir = ($urandom_range(0, 49) == 0);
      rpc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      stepCycle(fen, rdy, redir, rpc, "rand");
      checkVal("rand_count_bound", {31'h0, count <= 3'(DEPTH)}, 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
